cps1_mmr: RTL and testbench
===========================

Name: cps1_mmr

Overview:
- Memory-mapped register block for the CPS-1 video subsystem, covering both CPS-A (ppu1) and CPS-B (ppu2) register windows.
- Holds scroll, VRAM base, palette and priority registers, and issues palette-copy and object-DMA strobes.
- Also holds a per-game configuration loaded byte-serially; this configuration defines CPS-B register addresses, ROM banking and layer masks.
- Sits between the 68000 bus decode and the scroll/object/colour-mixer/DMA blocks.

Parameters:
- REGSIZE, 23, number of configuration bytes loaded through cfg_we/cfg_data.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- ppu_rstn  in  1  CPU-controlled synchronous clear of CPS-A/B registers, active-low
- ppu1_cs, ppu2_cs  in  1 each  CPS-A / CPS-B window selects
- rnw  in  1  1 = read, 0 = write
- addr  in  5  word address [5:1]
- dsn  in  2  byte enables, active-low; [1] = high byte
- cpu_dout  in  16  write data
- mmr_dout  out  16  read data
- cfg_we  in  1  configuration byte strobe
- cfg_data  in  8  configuration byte
- start_button, coin_input  in  4 each  inputs readable through CPS-B
- joystick1..4  in  10 each  inputs readable through CPS-B
- ppu_ctrl, hpos1..3, vpos1..3, hstar1, hstar2, vstar1, vstar2  out  16 each
- vram1_base, vram2_base, vram3_base, vram_obj_base, vram_row_base, row_offset, pal_base  out  16 each
- layer_ctrl, prio0..3  out  16 each
- layer_mask0..4  out  8 each
- pal_page_en  out  6
- game  out  6
- bank_offset, bank_mask  out  16 each
- pal_copy, obj_dma_ok  out  1 each  one-cycle strobes
- cpu_speed, charger  out  1 each

Behaviour:
- rst low: every register, every output and the configuration go to 0; mmr_dout resets to 16'hFFFF.
- ppu_rstn low: clears the CPS-A/B registers and strobes on each clock edge; the configuration is kept.
- Write rule:
  - Applies on each clock with cs=1, rnw=0.
  - Each byte lane is written only when its dsn bit is 0.
  - Registers hold their value otherwise.
- CPS-A map (byte offset):
  - 00 vram_obj_base, 02 vram1_base, 04 vram2_base, 06 vram3_base, 08 vram_row_base, 0A pal_base
  - 0C/0E hpos1/vpos1, 10/12 hpos2/vpos2, 14/16 hpos3/vpos3
  - 18/1A hstar1/vstar1, 1C/1E hstar2/vstar2
  - 20 row_offset, 22 ppu_ctrl
  - Other offsets are ignored.
- Strobes:
  - obj_dma_ok pulses for 1 clk on the rising edge of a CPS-A write select to 00.
  - pal_copy pulses for 1 clk on the rising edge of a CPS-A write select to 0A.
  - A select held for several cycles gives one pulse.
- Configuration load:
  - Each cfg_we cycle shifts cfg_data in, and all bytes move down one index.
  - After REGSIZE writes, the first byte written sits at index 0.
- Configuration byte map:
  - 0 game[5:0]
  - 1/2 bank_offset hi/lo, 3/4 bank_mask hi/lo
  - 5 layer_ctrl addr, 6..9 prio0..3 addr, 10 pal_page_en addr
  - 11 input-port addr, 12 ID addr, 13/14 ID value hi/lo
  - 15..19 layer_mask0..4
  - 20 bit0 = cpu_speed, bit1 = charger
  - 21, 22 reserved
- Address bytes hold a byte offset; bit0 is ignored and compared against {addr,1'b0}.
- CPS-B window:
  - A write whose offset matches a configured address updates the corresponding register; pal_page_en takes the low 6 bits.
  - If several address bytes match, the lowest byte index wins.
  - An address byte of 8'hFF never matches.
- Reads (latency 1):
  - mmr_dout is registered on the clock with cs=1, rnw=1 and holds between reads.
  - CPS-B ID address returns the ID value.
  - CPS-B input-port address returns {start_button, coin_input, joystick3[7:0]}.
  - Other CPS-B offsets return 16'hFFFF.
  - CPS-A reads return 16'hFFFF.
- ppu1_cs and ppu2_cs both high: ppu1 has priority.

Optional Feature:
- Macro CPSA_READBACK_EN.
- Defined: CPS-A reads return the stored register value at the matching offset; unmapped offsets return 16'hFFFF.
- Undefined: all CPS-A reads return 16'hFFFF.

Decomposition:
- Package cps1_mmr_pkg holds the CPS-A offset localparams, the configuration byte indices and the 16'hFFFF idle read constant.
- One natural sub-module: cps1_cfg_shift, the REGSIZE-byte configuration shift register with decoded field outputs.

Test Plan:
- Reset: assert rst=0, then release -> all outputs 0 and mmr_dout=16'hFFFF.
- Byte lanes: write CPS-A 0C with 16'h1234 and dsn=2'b10 -> hpos1=16'h0034; then write 16'hAB00 with dsn=2'b01 -> hpos1=16'hAB34.
- Strobes: write CPS-A 0A, select held 3 cycles -> exactly one pal_copy pulse, pal_base updated; write to 00 -> one obj_dma_ok pulse.
- Configuration: load 23 bytes with byte12=8'h32, bytes13/14=8'h04/8'h08; then CPS-B read at 32 -> mmr_dout=16'h0408 one cycle later.
- CPS-B write: layer_ctrl addr byte=8'h26, write 16'h12CE to 26 -> layer_ctrl=16'h12CE; write to an unconfigured address -> no register change.
- ppu_rstn=0 for 1 cycle -> scroll/base registers 0 while game, bank_offset and layer masks keep their loaded values.

Source files
------------

// File: rtl/cps1_mmr_pkg.sv
// cps1_mmr_pkg: shared constants for the CPS-1 memory-mapped register block.
// CPS-A word addresses, configuration byte indices, CPS-B slot encoding
// and small helpers for byte-lane merging and configured-address matching.
package cps1_mmr_pkg;

  typedef logic [4:0] word_addr_t;

  localparam logic [15:0] IDLE_READ = 16'hFFFF;

  // CPS-A word addresses (byte offset / 2)
  localparam word_addr_t A_OBJ_BASE  = 5'h00;
  localparam word_addr_t A_VRAM1     = 5'h01;
  localparam word_addr_t A_VRAM2     = 5'h02;
  localparam word_addr_t A_VRAM3     = 5'h03;
  localparam word_addr_t A_ROW_BASE  = 5'h04;
  localparam word_addr_t A_PAL_BASE  = 5'h05;
  localparam word_addr_t A_HPOS1     = 5'h06;
  localparam word_addr_t A_VPOS1     = 5'h07;
  localparam word_addr_t A_HPOS2     = 5'h08;
  localparam word_addr_t A_VPOS2     = 5'h09;
  localparam word_addr_t A_HPOS3     = 5'h0A;
  localparam word_addr_t A_VPOS3     = 5'h0B;
  localparam word_addr_t A_HSTAR1    = 5'h0C;
  localparam word_addr_t A_VSTAR1    = 5'h0D;
  localparam word_addr_t A_HSTAR2    = 5'h0E;
  localparam word_addr_t A_VSTAR2    = 5'h0F;
  localparam word_addr_t A_ROW_OFF   = 5'h10;
  localparam word_addr_t A_PPU_CTRL  = 5'h11;
  localparam int         CPSA_NREGS  = 18;

  // Configuration byte indices
  localparam int CFG_GAME            = 0;
  localparam int CFG_BANK_OFF_HI     = 1;
  localparam int CFG_BANK_OFF_LO     = 2;
  localparam int CFG_BANK_MASK_HI    = 3;
  localparam int CFG_BANK_MASK_LO    = 4;
  localparam int CFG_LAYER_CTRL_ADDR = 5;
  localparam int CFG_PRIO0_ADDR      = 6;
  localparam int CFG_PAL_PAGE_ADDR   = 10;
  localparam int CFG_INPUT_ADDR      = 11;
  localparam int CFG_ID_ADDR         = 12;
  localparam int CFG_ID_HI           = 13;
  localparam int CFG_ID_LO           = 14;
  localparam int CFG_LMASK0          = 15;
  localparam int CFG_MISC            = 20;
  localparam int CFG_RSVD0           = 21;
  localparam int CFG_RSVD1           = 22;

  // CPS-B address bytes 5..12 in index order; lower slot wins on overlap
  localparam int CPSB_NADDR = 8;
  localparam int CPSB_NREGS = 6;
  typedef enum logic [2:0] {
    B_LAYER_CTRL = 3'd0,
    B_PRIO0      = 3'd1,
    B_PRIO1      = 3'd2,
    B_PRIO2      = 3'd3,
    B_PRIO3      = 3'd4,
    B_PAL_PAGE   = 3'd5,
    B_INPUT      = 3'd6,
    B_ID         = 3'd7
  } cpsb_slot_e;

  // Configured byte offset vs bus word address; bit0 ignored, 8'hFF disables
  function automatic logic cfg_addr_hit(logic [7:0] cfg_byte, word_addr_t word_addr);
    return (cfg_byte != 8'hFF) && (cfg_byte[7:1] == {2'b00, word_addr});
  endfunction

  // Active-low byte enables: dsn[1] gates the high byte, dsn[0] the low byte
  function automatic logic [15:0] lane_merge(logic [15:0] old_val, logic [15:0] wr_val,
                                             logic [1:0] dsn);
    logic [15:0] res;
    res = old_val;
    if (!dsn[1]) res[15:8] = wr_val[15:8];
    if (!dsn[0]) res[7:0]  = wr_val[7:0];
    return res;
  endfunction

endpackage

// File: rtl/cps1_mmr_if.sv
// cps1_mmr_if: 68000-side bus for the CPS-A/CPS-B register windows.
interface cps1_mmr_if;
  import cps1_mmr_pkg::*;

  logic        ppu1_cs;
  logic        ppu2_cs;
  logic        rnw;
  word_addr_t  addr;
  logic [1:0]  dsn;
  logic [15:0] cpu_dout;
  logic [15:0] mmr_dout;

  modport master (output ppu1_cs, ppu2_cs, rnw, addr, dsn, cpu_dout, input mmr_dout);
  modport slave  (input ppu1_cs, ppu2_cs, rnw, addr, dsn, cpu_dout, output mmr_dout);
endinterface

// File: rtl/cps1_cfg_shift.sv
// cps1_cfg_shift: per-game configuration, loaded one byte per i_cfg_we.
// Bytes move toward index 0 so the first of REGSIZE bytes ends at index 0.
// Outputs are straight decodes of fixed byte positions.
module cps1_cfg_shift
  import cps1_mmr_pkg::*;
#(
  parameter int REGSIZE = 23
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_cfg_we,
  input  logic [7:0]                  i_cfg_data,
  output logic [5:0]                  o_game,
  output logic [15:0]                 o_bank_offset,
  output logic [15:0]                 o_bank_mask,
  output logic [CPSB_NADDR-1:0][7:0]  o_cpsb_addr,
  output logic [15:0]                 o_id_value,
  output logic [4:0][7:0]             o_layer_mask,
  output logic                        o_cpu_speed,
  output logic                        o_charger
);

  logic [7:0] r_cfg [REGSIZE];
  logic       w_unused_cfg;

  // Shift register: newest byte enters at the top index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REGSIZE; i++) r_cfg[i] <= '0;
    end else if (i_cfg_we) begin
      for (int i = 0; i < REGSIZE - 1; i++) r_cfg[i] <= r_cfg[i+1];
      r_cfg[REGSIZE-1] <= i_cfg_data;
    end
  end

  assign o_game        = r_cfg[CFG_GAME][5:0];
  assign o_bank_offset = {r_cfg[CFG_BANK_OFF_HI], r_cfg[CFG_BANK_OFF_LO]};
  assign o_bank_mask   = {r_cfg[CFG_BANK_MASK_HI], r_cfg[CFG_BANK_MASK_LO]};
  assign o_id_value    = {r_cfg[CFG_ID_HI], r_cfg[CFG_ID_LO]};
  assign o_cpu_speed   = r_cfg[CFG_MISC][0];
  assign o_charger     = r_cfg[CFG_MISC][1];

  genvar gi;
  generate
    for (gi = 0; gi < CPSB_NADDR; gi++) begin : g_addr
      assign o_cpsb_addr[gi] = r_cfg[CFG_LAYER_CTRL_ADDR + gi];
    end
    for (gi = 0; gi < 5; gi++) begin : g_lmask
      assign o_layer_mask[gi] = r_cfg[CFG_LMASK0 + gi];
    end
  endgenerate

  // Reserved bytes and spare bits carry no function
  assign w_unused_cfg = ^{r_cfg[CFG_GAME][7:6], r_cfg[CFG_MISC][7:2],
                          r_cfg[CFG_RSVD0], r_cfg[CFG_RSVD1]};

endmodule

// File: rtl/cps1_mmr.sv
// cps1_mmr: CPS-1 CPS-A/CPS-B memory-mapped register block.
// CPS-A registers live at fixed offsets; CPS-B register addresses come from
// the per-game configuration held in cps1_cfg_shift. Reads have one cycle of
// latency and mmr_dout holds between reads.
// Optional macro CPSA_READBACK_EN: CPS-A reads return the stored register
// (unmapped offsets 16'hFFFF); without it every CPS-A read returns 16'hFFFF.
module cps1_mmr
  import cps1_mmr_pkg::*;
#(
  parameter int REGSIZE = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ppu_rstn,
  cps1_mmr_if.slave    bus,
  input  logic         cfg_we,
  input  logic [7:0]   cfg_data,
  input  logic [3:0]   start_button,
  input  logic [3:0]   coin_input,
  input  logic [9:0]   joystick1,
  input  logic [9:0]   joystick2,
  input  logic [9:0]   joystick3,
  input  logic [9:0]   joystick4,
  output logic [15:0]  ppu_ctrl,
  output logic [15:0]  hpos1,
  output logic [15:0]  hpos2,
  output logic [15:0]  hpos3,
  output logic [15:0]  vpos1,
  output logic [15:0]  vpos2,
  output logic [15:0]  vpos3,
  output logic [15:0]  hstar1,
  output logic [15:0]  hstar2,
  output logic [15:0]  vstar1,
  output logic [15:0]  vstar2,
  output logic [15:0]  vram1_base,
  output logic [15:0]  vram2_base,
  output logic [15:0]  vram3_base,
  output logic [15:0]  vram_obj_base,
  output logic [15:0]  vram_row_base,
  output logic [15:0]  row_offset,
  output logic [15:0]  pal_base,
  output logic [15:0]  layer_ctrl,
  output logic [15:0]  prio0,
  output logic [15:0]  prio1,
  output logic [15:0]  prio2,
  output logic [15:0]  prio3,
  output logic [7:0]   layer_mask0,
  output logic [7:0]   layer_mask1,
  output logic [7:0]   layer_mask2,
  output logic [7:0]   layer_mask3,
  output logic [7:0]   layer_mask4,
  output logic [5:0]   pal_page_en,
  output logic [5:0]   game,
  output logic [15:0]  bank_offset,
  output logic [15:0]  bank_mask,
  output logic         pal_copy,
  output logic         obj_dma_ok,
  output logic         cpu_speed,
  output logic         charger
);

  logic [CPSB_NADDR-1:0][7:0] w_cpsb_addr;
  logic [15:0]                w_id_value;
  logic [4:0][7:0]            w_layer_mask;
  logic [CPSB_NADDR-1:0]      w_addr_hit;
  logic                       w_hit_any;
  logic [2:0]                 w_hit_idx;
  logic                       w_cpsa_sel;
  logic                       w_cpsb_sel;
  logic                       w_cpsa_wr;
  logic                       w_cpsb_wr;
  logic                       w_obj_sel;
  logic                       w_pal_sel;
  logic [15:0]                w_rdata;
  logic                       w_unused_inputs;

  logic [15:0] r_cpsa [CPSA_NREGS];
  logic [15:0] r_cpsb [CPSB_NREGS];
  logic        r_obj_sel_d;
  logic        r_pal_sel_d;
  logic        r_obj_dma_ok;
  logic        r_pal_copy;
  logic [15:0] r_mmr_dout;

  cps1_cfg_shift #(.REGSIZE(REGSIZE)) u_cfg (
    .clk           (clk),
    .rst           (rst),
    .i_cfg_we      (cfg_we),
    .i_cfg_data    (cfg_data),
    .o_game        (game),
    .o_bank_offset (bank_offset),
    .o_bank_mask   (bank_mask),
    .o_cpsb_addr   (w_cpsb_addr),
    .o_id_value    (w_id_value),
    .o_layer_mask  (w_layer_mask),
    .o_cpu_speed   (cpu_speed),
    .o_charger     (charger)
  );

  // ppu1 wins when both windows are selected
  assign w_cpsa_sel = bus.ppu1_cs;
  assign w_cpsb_sel = bus.ppu2_cs & ~bus.ppu1_cs;
  assign w_cpsa_wr  = w_cpsa_sel & ~bus.rnw;
  assign w_cpsb_wr  = w_cpsb_sel & ~bus.rnw;
  assign w_obj_sel  = w_cpsa_wr & (bus.addr == A_OBJ_BASE);
  assign w_pal_sel  = w_cpsa_wr & (bus.addr == A_PAL_BASE);

  genvar gi;
  generate
    for (gi = 0; gi < CPSB_NADDR; gi++) begin : g_hit
      assign w_addr_hit[gi] = cfg_addr_hit(w_cpsb_addr[gi], bus.addr);
    end
  endgenerate

  // Priority encode configured-address matches; the lowest byte index wins
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_idx = '0;
    for (int i = CPSB_NADDR - 1; i >= 0; i--) begin
      if (w_addr_hit[i]) begin
        w_hit_any = 1'b1;
        w_hit_idx = 3'(i);
      end
    end
  end

  // CPS-A registers: fixed word addresses, byte-lane writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CPSA_NREGS; i++) r_cpsa[i] <= '0;
    end else if (!ppu_rstn) begin
      for (int i = 0; i < CPSA_NREGS; i++) r_cpsa[i] <= '0;
    end else if (w_cpsa_wr && (bus.addr < 5'(CPSA_NREGS))) begin
      r_cpsa[bus.addr] <= lane_merge(r_cpsa[bus.addr], bus.cpu_dout, bus.dsn);
    end
  end

  // CPS-B registers: written only when the winning match is a writable slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CPSB_NREGS; i++) r_cpsb[i] <= '0;
    end else if (!ppu_rstn) begin
      for (int i = 0; i < CPSB_NREGS; i++) r_cpsb[i] <= '0;
    end else if (w_cpsb_wr && w_hit_any && (w_hit_idx < 3'(CPSB_NREGS))) begin
      r_cpsb[w_hit_idx] <= lane_merge(r_cpsb[w_hit_idx], bus.cpu_dout, bus.dsn);
    end
  end

  // One-cycle strobes on the first cycle of a CPS-A write select to 00 / 0A
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_obj_sel_d  <= 1'b0;
      r_pal_sel_d  <= 1'b0;
      r_obj_dma_ok <= 1'b0;
      r_pal_copy   <= 1'b0;
    end else if (!ppu_rstn) begin
      r_obj_sel_d  <= 1'b0;
      r_pal_sel_d  <= 1'b0;
      r_obj_dma_ok <= 1'b0;
      r_pal_copy   <= 1'b0;
    end else begin
      r_obj_sel_d  <= w_obj_sel;
      r_pal_sel_d  <= w_pal_sel;
      r_obj_dma_ok <= w_obj_sel & ~r_obj_sel_d;
      r_pal_copy   <= w_pal_sel & ~r_pal_sel_d;
    end
  end

  // Read data selection for the current bus cycle
  always_comb begin
    w_rdata = IDLE_READ;
    if (w_cpsa_sel) begin
`ifdef CPSA_READBACK_EN
      if (bus.addr < 5'(CPSA_NREGS)) w_rdata = r_cpsa[bus.addr];
`endif
    end else if (w_cpsb_sel && w_hit_any) begin
      case (cpsb_slot_e'(w_hit_idx))
        B_ID:    w_rdata = w_id_value;
        B_INPUT: w_rdata = {start_button, coin_input, joystick3[7:0]};
        default: w_rdata = IDLE_READ;
      endcase
    end
  end

  // Registered read port; holds its value between reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mmr_dout <= IDLE_READ;
    end else if ((bus.ppu1_cs || bus.ppu2_cs) && bus.rnw) begin
      r_mmr_dout <= w_rdata;
    end
  end

  assign bus.mmr_dout  = r_mmr_dout;
  assign obj_dma_ok    = r_obj_dma_ok;
  assign pal_copy      = r_pal_copy;

  assign vram_obj_base = r_cpsa[A_OBJ_BASE];
  assign vram1_base    = r_cpsa[A_VRAM1];
  assign vram2_base    = r_cpsa[A_VRAM2];
  assign vram3_base    = r_cpsa[A_VRAM3];
  assign vram_row_base = r_cpsa[A_ROW_BASE];
  assign pal_base      = r_cpsa[A_PAL_BASE];
  assign hpos1         = r_cpsa[A_HPOS1];
  assign vpos1         = r_cpsa[A_VPOS1];
  assign hpos2         = r_cpsa[A_HPOS2];
  assign vpos2         = r_cpsa[A_VPOS2];
  assign hpos3         = r_cpsa[A_HPOS3];
  assign vpos3         = r_cpsa[A_VPOS3];
  assign hstar1        = r_cpsa[A_HSTAR1];
  assign vstar1        = r_cpsa[A_VSTAR1];
  assign hstar2        = r_cpsa[A_HSTAR2];
  assign vstar2        = r_cpsa[A_VSTAR2];
  assign row_offset    = r_cpsa[A_ROW_OFF];
  assign ppu_ctrl      = r_cpsa[A_PPU_CTRL];

  assign layer_ctrl    = r_cpsb[B_LAYER_CTRL];
  assign prio0         = r_cpsb[B_PRIO0];
  assign prio1         = r_cpsb[B_PRIO1];
  assign prio2         = r_cpsb[B_PRIO2];
  assign prio3         = r_cpsb[B_PRIO3];
  assign pal_page_en   = r_cpsb[B_PAL_PAGE][5:0];

  assign layer_mask0   = w_layer_mask[0];
  assign layer_mask1   = w_layer_mask[1];
  assign layer_mask2   = w_layer_mask[2];
  assign layer_mask3   = w_layer_mask[3];
  assign layer_mask4   = w_layer_mask[4];

  // Only joystick3[7:0] is visible through the input port
  assign w_unused_inputs = ^{joystick1, joystick2, joystick4, joystick3[9:8],
                             r_cpsb[B_PAL_PAGE][15:6]};

endmodule

// File: tb/tb_cps1_mmr.sv
// tb_cps1_mmr: scoreboard bench for cps1_mmr. Stimulus updates a behavioural
// model and queues expected values tagged with the cycle they must appear;
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cps1_mmr;
  import cps1_mmr_pkg::*;

  localparam int K_DOUT = 0, K_PAL = 1, K_OBJ = 2, K_CPSA = 3, K_CPSB = 4, K_GAME = 5;
  localparam int K_BOFF = 6, K_BMASK = 7, K_LMASK = 8, K_SPEED = 9, K_CHG = 10;

  logic clk = 1'b0;
  logic rst, ppu_rstn, cfg_we;
  logic [7:0] cfg_data;
  logic [3:0] start_button, coin_input;
  logic [9:0] joystick1, joystick2, joystick3, joystick4;
  logic [15:0] ppu_ctrl, hpos1, hpos2, hpos3, vpos1, vpos2, vpos3;
  logic [15:0] hstar1, hstar2, vstar1, vstar2;
  logic [15:0] vram1_base, vram2_base, vram3_base, vram_obj_base, vram_row_base, row_offset, pal_base;
  logic [15:0] layer_ctrl, prio0, prio1, prio2, prio3;
  logic [7:0] layer_mask0, layer_mask1, layer_mask2, layer_mask3, layer_mask4;
  logic [5:0] pal_page_en, game;
  logic [15:0] bank_offset, bank_mask;
  logic pal_copy, obj_dma_ok, cpu_speed, charger;

  cps1_mmr_if bus();

  always #5 clk = ~clk;

  cps1_mmr #(.REGSIZE(23)) dut (
    .clk(clk), .rst(rst), .ppu_rstn(ppu_rstn), .bus(bus),
    .cfg_we(cfg_we), .cfg_data(cfg_data),
    .start_button(start_button), .coin_input(coin_input),
    .joystick1(joystick1), .joystick2(joystick2), .joystick3(joystick3), .joystick4(joystick4),
    .ppu_ctrl(ppu_ctrl), .hpos1(hpos1), .hpos2(hpos2), .hpos3(hpos3),
    .vpos1(vpos1), .vpos2(vpos2), .vpos3(vpos3),
    .hstar1(hstar1), .hstar2(hstar2), .vstar1(vstar1), .vstar2(vstar2),
    .vram1_base(vram1_base), .vram2_base(vram2_base), .vram3_base(vram3_base),
    .vram_obj_base(vram_obj_base), .vram_row_base(vram_row_base),
    .row_offset(row_offset), .pal_base(pal_base),
    .layer_ctrl(layer_ctrl), .prio0(prio0), .prio1(prio1), .prio2(prio2), .prio3(prio3),
    .layer_mask0(layer_mask0), .layer_mask1(layer_mask1), .layer_mask2(layer_mask2),
    .layer_mask3(layer_mask3), .layer_mask4(layer_mask4),
    .pal_page_en(pal_page_en), .game(game),
    .bank_offset(bank_offset), .bank_mask(bank_mask),
    .pal_copy(pal_copy), .obj_dma_ok(obj_dma_ok),
    .cpu_speed(cpu_speed), .charger(charger)
  );

  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [15:0] exp;
  } chk_t;

  chk_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  logic [15:0] m_cpsa [18];   // indexed by byte offset / 2
  logic [15:0] m_cpsb [6];    // layer_ctrl, prio0..3, pal_page_en
  logic [7:0]  m_cfg [$];     // configuration bytes, index 0 first
  logic [15:0] m_dout;

  function automatic logic [15:0] lanes(logic [15:0] old_v, logic [15:0] d, logic [1:0] dsn);
    logic [15:0] r;
    r = old_v;
    if (dsn[1] == 1'b0) r[15:8] = d[15:8];
    if (dsn[0] == 1'b0) r[7:0]  = d[7:0];
    return r;
  endfunction

  // Lowest configuration index among 5..12 whose byte offset matches
  function automatic int cpsb_hit(int a);
    for (int i = 5; i <= 12; i++)
      if (m_cfg[i] != 8'hFF && (m_cfg[i] & 8'hFE) == 8'(a * 2)) return i;
    return -1;
  endfunction

  function automatic logic [15:0] model_read(bit s1, int a);
    int h;
    if (s1) begin
`ifdef CPSA_READBACK_EN
      if (a < 18) return m_cpsa[a];
`endif
      return 16'hFFFF;
    end
    h = cpsb_hit(a);
    if (h == 12) return {m_cfg[13], m_cfg[14]};
    if (h == 11) return {start_button, coin_input, joystick3[7:0]};
    return 16'hFFFF;
  endfunction

  function automatic logic [15:0] cpsb_exp(int j);
    if (j == 5) return {10'b0, m_cpsb[5][5:0]};
    return m_cpsb[j];
  endfunction

  // ---------------- DUT observation ----------------
  function automatic logic [15:0] dut_val(int kind, int idx);
    case (kind)
      K_DOUT:  return bus.mmr_dout;
      K_PAL:   return {15'b0, pal_copy};
      K_OBJ:   return {15'b0, obj_dma_ok};
      K_CPSA: begin
        case (idx)
          0: return vram_obj_base;  1: return vram1_base;  2: return vram2_base;
          3: return vram3_base;     4: return vram_row_base; 5: return pal_base;
          6: return hpos1;          7: return vpos1;       8: return hpos2;
          9: return vpos2;          10: return hpos3;      11: return vpos3;
          12: return hstar1;        13: return vstar1;     14: return hstar2;
          15: return vstar2;        16: return row_offset; default: return ppu_ctrl;
        endcase
      end
      K_CPSB: begin
        case (idx)
          0: return layer_ctrl; 1: return prio0; 2: return prio1;
          3: return prio2;      4: return prio3; default: return {10'b0, pal_page_en};
        endcase
      end
      K_GAME:  return {10'b0, game};
      K_BOFF:  return bank_offset;
      K_BMASK: return bank_mask;
      K_LMASK: begin
        case (idx)
          0: return {8'b0, layer_mask0}; 1: return {8'b0, layer_mask1};
          2: return {8'b0, layer_mask2}; 3: return {8'b0, layer_mask3};
          default: return {8'b0, layer_mask4};
        endcase
      end
      K_SPEED: return {15'b0, cpu_speed};
      default: return {15'b0, charger};
    endcase
  endfunction

  function automatic string kname(int kind, int idx);
    case (kind)
      K_DOUT:  return "mmr_dout";
      K_PAL:   return "pal_copy";
      K_OBJ:   return "obj_dma_ok";
      K_CPSA:  return $sformatf("cpsa_off%02h", idx * 2);
      K_CPSB:  return $sformatf("cpsb_reg%0d", idx);
      K_GAME:  return "game";
      K_BOFF:  return "bank_offset";
      K_BMASK: return "bank_mask";
      K_LMASK: return $sformatf("layer_mask%0d", idx);
      K_SPEED: return "cpu_speed";
      default: return "charger";
    endcase
  endfunction

  task automatic sb_push(int at, int kind, int idx, logic [15:0] v);
    chk_t c;
    c.cyc = at; c.kind = kind; c.idx = idx; c.exp = v;
    sbq.push_back(c);
  endtask

  // ---------------- monitor ----------------
  chk_t        mon_c;
  logic [15:0] mon_act;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_c   = sbq.pop_front();
      mon_act = dut_val(mon_c.kind, mon_c.idx);
      n_checks++;
      if (mon_c.cyc != cyc) begin
        n_errors++;
        $display("FAIL %s: check due at cycle %0d not sampled until cycle %0d",
                 kname(mon_c.kind, mon_c.idx), mon_c.cyc, cyc);
      end else if (mon_act !== mon_c.exp) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h at cycle %0d",
                 kname(mon_c.kind, mon_c.idx), mon_act, mon_c.exp, cyc);
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic push_cfg_checks(int at);
    sb_push(at, K_GAME, 0, {10'b0, m_cfg[0][5:0]});
    sb_push(at, K_BOFF, 0, {m_cfg[1], m_cfg[2]});
    sb_push(at, K_BMASK, 0, {m_cfg[3], m_cfg[4]});
    for (int i = 0; i < 5; i++) sb_push(at, K_LMASK, i, {8'b0, m_cfg[15 + i]});
    sb_push(at, K_SPEED, 0, {15'b0, m_cfg[20][0]});
    sb_push(at, K_CHG, 0, {15'b0, m_cfg[20][1]});
  endtask

  // One bus cycle followed by one idle cycle
  task automatic bus_op(bit s1, bit s2, bit rd, int a, logic [1:0] dsn, logic [15:0] d);
    int at, h;
    @(posedge clk); #1;
    bus.ppu1_cs = s1; bus.ppu2_cs = s2; bus.rnw = rd;
    bus.addr = 5'(a); bus.dsn = dsn; bus.cpu_dout = d;
    at = cyc + 1;
    $display("op cyc=%0d cs1=%0d cs2=%0d rnw=%0d off=%02h dsn=%b data=%h",
             at, s1, s2, rd, a * 2, dsn, d);
    if (rd) begin
      if (s1 || s2) m_dout = model_read(s1, a);
    end else if (s1) begin
      if (a < 18) m_cpsa[a] = lanes(m_cpsa[a], d, dsn);
    end else if (s2) begin
      h = cpsb_hit(a);
      if (h >= 5 && h <= 10) m_cpsb[h - 5] = lanes(m_cpsb[h - 5], d, dsn);
    end
    sb_push(at, K_DOUT, 0, m_dout);
    sb_push(at, K_PAL, 0, {15'b0, (s1 && !rd && a == 5)});
    sb_push(at, K_OBJ, 0, {15'b0, (s1 && !rd && a == 0)});
    if (!rd && s1 && a < 18) sb_push(at, K_CPSA, a, m_cpsa[a]);
    if (!rd && !s1 && s2) for (int j = 0; j < 6; j++) sb_push(at, K_CPSB, j, cpsb_exp(j));
    @(posedge clk); #1;
    bus.ppu1_cs = 1'b0; bus.ppu2_cs = 1'b0; bus.rnw = 1'b1;
  endtask

  // CPS-A write with the select held for n cycles
  task automatic bus_hold(int a, logic [15:0] d, int n);
    int at;
    @(posedge clk); #1;
    bus.ppu1_cs = 1'b1; bus.ppu2_cs = 1'b0; bus.rnw = 1'b0;
    bus.addr = 5'(a); bus.dsn = 2'b00; bus.cpu_dout = d;
    at = cyc + 1;
    $display("op cyc=%0d held-write off=%02h data=%h cycles=%0d", at, a * 2, d, n);
    m_cpsa[a] = d;
    for (int k = 0; k <= n; k++) begin
      if (k == 0) sb_push(at, K_CPSA, a, m_cpsa[a]);
      sb_push(at + k, K_PAL, 0, {15'b0, (k == 0 && a == 5)});
      sb_push(at + k, K_OBJ, 0, {15'b0, (k == 0 && a == 0)});
    end
    repeat (n) @(posedge clk);
    #1;
    bus.ppu1_cs = 1'b0; bus.rnw = 1'b1;
  endtask

  task automatic cfg_load(input logic [7:0] b [23]);
    for (int i = 0; i < 23; i++) begin
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_data = b[i];
      void'(m_cfg.pop_front());
      m_cfg.push_back(b[i]);
    end
    @(posedge clk); #1;
    cfg_we = 1'b0;
    $display("op cyc=%0d config loaded", cyc);
    push_cfg_checks(cyc);
  endtask

  task automatic ppu_clear();
    int at;
    @(posedge clk); #1;
    ppu_rstn = 1'b0;
    at = cyc + 1;
    for (int i = 0; i < 18; i++) m_cpsa[i] = '0;
    for (int i = 0; i < 6; i++) m_cpsb[i] = '0;
    @(posedge clk); #1;
    ppu_rstn = 1'b1;
    $display("op cyc=%0d ppu_rstn pulse", at);
    for (int i = 0; i < 18; i++) sb_push(at, K_CPSA, i, m_cpsa[i]);
    for (int j = 0; j < 6; j++) sb_push(at, K_CPSB, j, cpsb_exp(j));
    sb_push(at, K_PAL, 0, 16'h0);
    sb_push(at, K_OBJ, 0, 16'h0);
    push_cfg_checks(at);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] tbl [23];
  bit rs1, rs2, rrd;
  int ra;

  initial begin
    rst = 1'b0; ppu_rstn = 1'b1; cfg_we = 1'b0; cfg_data = '0;
    start_button = '0; coin_input = '0;
    joystick1 = '0; joystick2 = '0; joystick3 = '0; joystick4 = '0;
    bus.ppu1_cs = 1'b0; bus.ppu2_cs = 1'b0; bus.rnw = 1'b1;
    bus.addr = '0; bus.dsn = 2'b11; bus.cpu_dout = '0;
    for (int i = 0; i < 18; i++) m_cpsa[i] = '0;
    for (int i = 0; i < 6; i++) m_cpsb[i] = '0;
    for (int i = 0; i < 23; i++) m_cfg.push_back(8'h00);
    m_dout = 16'hFFFF;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    sb_push(cyc, K_DOUT, 0, m_dout);
    sb_push(cyc, K_PAL, 0, 16'h0);
    sb_push(cyc, K_OBJ, 0, 16'h0);
    for (int i = 0; i < 18; i++) sb_push(cyc, K_CPSA, i, m_cpsa[i]);
    for (int j = 0; j < 6; j++) sb_push(cyc, K_CPSB, j, cpsb_exp(j));
    push_cfg_checks(cyc);

    // Byte lanes on hpos1 (offset 0C)
    bus_op(1, 0, 0, 6, 2'b10, 16'h1234);
    bus_op(1, 0, 0, 6, 2'b01, 16'hAB00);

    // Strobes: held select gives one pulse
    bus_hold(5, 16'h0123, 3);
    bus_hold(0, 16'h4560, 2);

    // Directed configuration
    for (int i = 0; i < 23; i++) tbl[i] = 8'($urandom);
    tbl[5] = 8'h26; tbl[6] = 8'h28; tbl[7] = 8'h2A; tbl[8] = 8'h2C; tbl[9] = 8'h2E;
    tbl[10] = 8'h30; tbl[11] = 8'h36; tbl[12] = 8'h32; tbl[13] = 8'h04; tbl[14] = 8'h08;
    cfg_load(tbl);

    // ID read, input-port read, CPS-A read
    bus_op(0, 1, 1, 8'h32 / 2, 2'b00, 16'h0);
    start_button = 4'hA; coin_input = 4'h5; joystick3 = 10'h3C3;
    bus_op(0, 1, 1, 8'h36 / 2, 2'b00, 16'h0);
    bus_op(1, 0, 1, 6, 2'b00, 16'h0);

    // CPS-B writes: configured and unconfigured address
    bus_op(0, 1, 0, 8'h26 / 2, 2'b00, 16'h12CE);
    bus_op(0, 1, 0, 8'h30 / 2, 2'b00, 16'hFFFF);
    bus_op(0, 1, 0, 8'h3C / 2, 2'b00, 16'h5A5A);
    bus_op(1, 1, 0, 8'h26 / 2, 2'b00, 16'h7777);

    // ppu_rstn keeps configuration
    bus_op(1, 0, 0, 8'h1C / 2, 2'b00, 16'hBEEF);
    ppu_clear();

    // Randomised configuration with overlapping and disabled addresses
    for (int i = 0; i < 23; i++) tbl[i] = 8'($urandom);
    for (int i = 5; i <= 12; i++)
      tbl[i] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'(8'h20 + $urandom_range(0, 31));
    cfg_load(tbl);

    for (int n = 0; n < 160; n++) begin
      rs1 = ($urandom_range(0, 3) == 0);
      rs2 = ($urandom_range(0, 3) != 0);
      rrd = $urandom_range(0, 1);
      ra  = $urandom_range(0, 1) ? 16 + $urandom_range(0, 15) : $urandom_range(0, 31);
      start_button = 4'($urandom); coin_input = 4'($urandom);
      joystick1 = 10'($urandom); joystick2 = 10'($urandom);
      joystick3 = 10'($urandom); joystick4 = 10'($urandom);
      bus_op(rs1, rs2, rrd, ra, 2'($urandom), 16'($urandom));
      if (n == 80) ppu_clear();
    end

    repeat (5) @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
